store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 140 ++++++++++++++
 tb/tb_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store unit: aligns register data onto 32-bit memory byte lanes and issues a single write per request.
// Latency: accept T, write T+1 (memory ready), done T+2; errors complete at T+1. No queuing; ready only in IDLE.
module store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [2:0]            i_func_3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_wstrb,
    input  logic                  i_mem_ready,
    output logic                  o_done,
    output logic                  o_store_addr_ma,
    output logic                  o_illegal_instr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [3:0]              mem_wstrb_q;
    logic                    done_q;
    logic                    ma_q;
    logic                    ill_q;

    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [3:0]              wstrb_d;
    logic                    ma_d;
    logic                    ill_d;

    // Lane replication and strobe decode straight from the request inputs.
    always_comb begin
        wdata_d = i_data;
        wstrb_d = 4'b0000;
        ma_d    = 1'b0;
        ill_d   = 1'b0;
        case (i_func_3)
            3'b000: begin
                wdata_d = {4{i_data[7:0]}};
                wstrb_d = 4'b0001 << i_addr[1:0];
            end
            3'b001: begin
                wdata_d = {2{i_data[15:0]}};
                wstrb_d = i_addr[1] ? 4'b1100 : 4'b0011;
                ma_d    = i_addr[0];
            end
            3'b010: begin
                wdata_d = i_data;
                wstrb_d = 4'b1111;
                ma_d    = (i_addr[1:0] != 2'b00);
            end
            default: begin
                ill_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b0;
            ma_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_we_q    <= 1'b0;
                    mem_wstrb_q <= 4'b0000;
                    done_q      <= 1'b0;
                    ma_q        <= 1'b0;
                    ill_q       <= 1'b0;
                    if (i_req_valid) begin
                        mem_addr_q  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= wdata_d;
                        if (ill_d || ma_d) begin
                            // Illegal wins: misaligned flag is only meaningful for a legal store.
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            ill_q   <= ill_d;
                            ma_q    <= ma_d & ~ill_d;
                        end else begin
                            state_q     <= WRITE;
                            mem_we_q    <= 1'b1;
                            mem_wstrb_q <= wstrb_d;
                        end
                    end
                end
                WRITE: begin
                    if (i_mem_ready) begin
                        state_q     <= RESP;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        done_q      <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ma_q    <= 1'b0;
                    ill_q   <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_we_q    <= 1'b0;
                    mem_wstrb_q <= 4'b0000;
                    done_q      <= 1'b0;
                    ma_q        <= 1'b0;
                    ill_q       <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready     = (state_q == IDLE) && !i_rst;
    assign o_mem_we        = mem_we_q;
    assign o_mem_addr      = mem_addr_q;
    assign o_mem_wdata     = mem_wdata_q;
    assign o_mem_wstrb     = mem_wstrb_q;
    assign o_done          = done_q;
    assign o_store_addr_ma = ma_q;
    assign o_illegal_instr = ill_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed vector bench for store_unit: table of single requests plus multi-cycle reset and back-to-back sequences.
module tb_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_func_3;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ready;
    logic        o_done;
    logic        o_store_addr_ma;
    logic        o_illegal_instr;

    int n_cmp = 0;
    int n_bad = 0;

    store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_func_3        (i_func_3),
        .i_addr          (i_addr),
        .i_data          (i_data),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_wstrb     (o_mem_wstrb),
        .i_mem_ready     (i_mem_ready),
        .o_done          (o_done),
        .o_store_addr_ma (o_store_addr_ma),
        .o_illegal_instr (o_illegal_instr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_ma;
        logic        e_ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_req(input vec_t v);
        int cyc;
        int wec;
        bit fin;
        bit err;
        err = v.e_ma | v.e_ill;
        @(negedge i_clk);
        chk("ready_before_req", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_func_3    = v.f3;
        i_addr      = v.addr;
        i_data      = v.data;
        i_mem_ready = 1'b0;
        cyc = 0;
        wec = 0;
        fin = 0;
        while (!fin && cyc < 40) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
            cyc++;
            if (o_mem_we) begin
                wec++;
                chk("mem_addr", o_mem_addr, v.e_addr);
                chk("mem_wdata", o_mem_wdata, v.e_wdata);
                chk("mem_wstrb", o_mem_wstrb, v.e_wstrb);
                chk("ready_in_write", o_req_ready, 0);
            end else begin
                chk("wstrb_outside_write", o_mem_wstrb, 0);
            end
            i_mem_ready = o_mem_we && (wec > v.delay);
            if (o_done) begin
                chk("done_cycle", cyc, err ? 1 : v.delay + 2);
                chk("we_cycles", wec, err ? 0 : v.delay + 1);
                chk("flag_ma", o_store_addr_ma, v.e_ma);
                chk("flag_ill", o_illegal_instr, v.e_ill);
                chk("ready_in_resp", o_req_ready, 0);
                fin = 1;
            end else begin
                chk("flags_idle", {o_store_addr_ma, o_illegal_instr}, 0);
            end
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no o_done within %0d cycles, expected one", cyc);
        end
        i_mem_ready = 1'b0;
        @(negedge i_clk);
        chk("done_one_cycle", o_done, 0);
        chk("ready_after_done", o_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] b2b_we[6];
        logic [31:0] b2b_done[6];
        logic [31:0] b2b_rdy[6];

        vecs[0]  = '{3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 32'h0000_2002, 32'h1234_5678, 3, 32'h0000_2000, 32'h5678_5678, 4'b1100, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 32'h0000_3001, 32'h0BAD_F00D, 0, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0};
        vecs[3]  = '{3'b011, 32'h0000_3001, 32'h0BAD_F00D, 0, 32'h0,         32'h0,         4'b0000, 1'b0, 1'b1};
        vecs[4]  = '{3'b000, 32'h0000_0000, 32'h1122_3344, 1, 32'h0000_0000, 32'h4444_4444, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 32'h0000_0005, 32'h0000_00A5, 0, 32'h0000_0004, 32'hA5A5_A5A5, 4'b0010, 1'b0, 1'b0};
        vecs[6]  = '{3'b000, 32'h7FFF_FFFE, 32'h0000_00C3, 0, 32'h7FFF_FFFC, 32'hC3C3_C3C3, 4'b0100, 1'b0, 1'b0};
        vecs[7]  = '{3'b001, 32'h0000_0010, 32'hFFFF_1234, 0, 32'h0000_0010, 32'h1234_1234, 4'b0011, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 32'h0000_0011, 32'hFFFF_1234, 0, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0};
        vecs[9]  = '{3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 2, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0};
        vecs[10] = '{3'b010, 32'h0000_0042, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,         4'b0000, 1'b1, 1'b0};
        vecs[11] = '{3'b111, 32'h0000_0000, 32'h1234_5678, 0, 32'h0,         32'h0,         4'b0000, 1'b0, 1'b1};
        vecs[12] = '{3'b100, 32'h0000_0001, 32'h1234_5678, 0, 32'h0,         32'h0,         4'b0000, 1'b0, 1'b1};

        b2b_we   = '{1, 0, 0, 1, 0, 0};
        b2b_done = '{0, 1, 0, 0, 1, 0};
        b2b_rdy  = '{0, 0, 1, 0, 0, 1};

        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_func_3    = 3'b000;
        i_addr      = '0;
        i_data      = '0;
        i_mem_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_wstrb", o_mem_wstrb, 0);
        chk("rst_done", o_done, 0);
        chk("rst_flags", {o_store_addr_ma, o_illegal_instr}, 0);
        i_rst = 1'b0;
        #1;
        chk("ready_first_cycle_after_rst", o_req_ready, 1);

        for (int i = 0; i < 13; i++) run_req(vecs[i]);

        // Reset in the second WRITE cycle abandons the write
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_func_3    = 3'b001;
        i_addr      = 32'h0000_2002;
        i_data      = 32'h1234_5678;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rw_we_c1", o_mem_we, 1);
        @(negedge i_clk);
        chk("rw_we_c2", o_mem_we, 1);
        i_rst = 1'b1;
        #1;
        chk("rw_ready_in_rst", o_req_ready, 0);
        @(negedge i_clk);
        chk("rw_we_after_rst", o_mem_we, 0);
        chk("rw_wstrb_after_rst", o_mem_wstrb, 0);
        chk("rw_done_after_rst", o_done, 0);
        chk("rw_addr_after_rst", o_mem_addr, 0);
        i_rst = 1'b0;
        #1;
        chk("rw_ready_after_deassert", o_req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("rw_no_done", o_done, 0);
            chk("rw_no_we", o_mem_we, 0);
        end

        // Reset on the handshake edge suppresses the pending done
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_func_3    = 3'b010;
        i_addr      = 32'h0000_0008;
        i_data      = 32'hCAFE_BABE;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rr_we", o_mem_we, 1);
        i_mem_ready = 1'b1;
        i_rst       = 1'b1;
        @(negedge i_clk);
        chk("rr_done_suppressed", o_done, 0);
        chk("rr_we_cleared", o_mem_we, 0);
        i_rst       = 1'b0;
        i_mem_ready = 1'b0;
        @(negedge i_clk);
        chk("rr_done_still_0", o_done, 0);
        chk("rr_ready", o_req_ready, 1);

        // Back-to-back SW with valid held: second only accepted after first done
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_func_3    = 3'b010;
        i_addr      = 32'h0000_0000;
        i_data      = 32'h1111_1111;
        i_mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (c == 0) begin
                i_addr = 32'h0000_0004;
                i_data = 32'h2222_2222;
            end
            if (c == 4) i_req_valid = 1'b0;
            chk("b2b_we", o_mem_we, b2b_we[c]);
            chk("b2b_done", o_done, b2b_done[c]);
            chk("b2b_ready", o_req_ready, b2b_rdy[c]);
            if (c == 0) begin
                chk("b2b_addr0", o_mem_addr, 32'h0000_0000);
                chk("b2b_wdata0", o_mem_wdata, 32'h1111_1111);
                chk("b2b_wstrb0", o_mem_wstrb, 4'b1111);
            end
            if (c == 3) begin
                chk("b2b_addr1", o_mem_addr, 32'h0000_0004);
                chk("b2b_wdata1", o_mem_wdata, 32'h2222_2222);
                chk("b2b_wstrb1", o_mem_wstrb, 4'b1111);
            end
        end
        i_mem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
